// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, one-hot
// T-state codes and the control-word bit layout.
package sap1_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  localparam int T_W = 6;

  localparam logic [T_W-1:0] T1 = 6'b000001;
  localparam logic [T_W-1:0] T2 = 6'b000010;
  localparam logic [T_W-1:0] T3 = 6'b000100;
  localparam logic [T_W-1:0] T4 = 6'b001000;
  localparam logic [T_W-1:0] T5 = 6'b010000;
  localparam logic [T_W-1:0] T6 = 6'b100000;

  localparam int CW_W  = 12;
  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_LM = 2;
  localparam int CW_ER = 3;
  localparam int CW_LI = 4;
  localparam int CW_EI = 5;
  localparam int CW_LA = 6;
  localparam int CW_EA = 7;
  localparam int CW_SU = 8;
  localparam int CW_EU = 9;
  localparam int CW_LB = 10;
  localparam int CW_LO = 11;

  typedef logic [CW_W-1:0] cw_t;

  localparam cw_t CW_NONE = '0;

  // One-hot control word with only the given control asserted.
  function automatic cw_t cw_bit(input int idx);
    return cw_t'(1) << idx;
  endfunction

  // Strobes that commit state on the leaving edge; masked while paused.
  localparam cw_t CW_LOAD_MASK = cw_bit(CW_CP) | cw_bit(CW_LM) | cw_bit(CW_LI) |
                                 cw_bit(CW_LA) | cw_bit(CW_LB) | cw_bit(CW_LO);

  // Everything that can drive the shared W bus.
  localparam cw_t CW_BUS_MASK = cw_bit(CW_EP) | cw_bit(CW_ER) | cw_bit(CW_EI) |
                                cw_bit(CW_EA) | cw_bit(CW_EU);

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot ring counter (T1..T6) with asynchronous clear to T1.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic           clk,
  input  logic           clr_n,
  input  logic           en,
  output logic [T_W-1:0] t_state
);

  // Rotate the one-hot token left by one position per enabled edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      t_state <= T1;
    end else if (en) begin
      t_state <= {t_state[T_W-2:0], t_state[T_W-1]};
    end
  end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: ring counter timing, opcode decode into one
// control word per T-state, single-step edge detect and latched halt.
//
// state | meaning
// T1    | PC onto bus, MAR load
// T2    | PC increment
// T3    | RAM onto bus, IR load
// T4-T6 | opcode-dependent execute phases
// HALT  | frozen in T4 with all controls low until clr_n
module sap1_controller_sequencer
  import sap1_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             run,
  input  logic             step,
  output logic             cp,
  output logic             ep,
  output logic             lm,
  output logic             er,
  output logic             li,
  output logic             ei,
  output logic             la,
  output logic             ea,
  output logic             su,
  output logic             eu,
  output logic             lb,
  output logic             lo,
  output logic [T_W-1:0]   t_state,
  output logic             halted
);

  logic step_q;
  logic step_rise;
  logic adv;
  logic hlt_hit;
  logic ring_en;
  cw_t  cw_raw;
  cw_t  cw;

  assign step_rise = step & ~step_q;
  assign adv       = run | step_rise;
  // HLT is caught on the edge leaving T4; the counter must not move on that edge.
  assign hlt_hit   = adv & ~halted & (t_state == T4) & (opcode == OP_HLT);
  assign ring_en   = adv & ~halted & ~hlt_hit;

  // Step edge register (sampled every cycle) and sticky halt flag.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step_q <= 1'b0;
      halted <= 1'b0;
    end else begin
      step_q <= step;
      if (hlt_hit) begin
        halted <= 1'b1;
      end
    end
  end

  sap1_ring_counter u_ring (
    .clk     (clk),
    .clr_n   (clr_n),
    .en      (ring_en),
    .t_state (t_state)
  );

  // Microcode decode: fetch is opcode independent, execute keys on opcode.
  always_comb begin
    cw_raw = CW_NONE;
    case (t_state)
      T1: cw_raw = cw_bit(CW_EP) | cw_bit(CW_LM);
      T2: cw_raw = cw_bit(CW_CP);
      T3: cw_raw = cw_bit(CW_ER) | cw_bit(CW_LI);
      T4: begin
        case (opcode)
          OP_LDA,
          OP_ADD:  cw_raw = cw_bit(CW_EI) | cw_bit(CW_LM);
          // su asserted early so the subtractor output has settled by T6.
          OP_SUB:  cw_raw = cw_bit(CW_EI) | cw_bit(CW_LM) | cw_bit(CW_SU);
          OP_OUT:  cw_raw = cw_bit(CW_EA) | cw_bit(CW_LO);
          OP_HLT:  cw_raw = CW_NONE;
          default: cw_raw = CW_NONE;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA:  cw_raw = cw_bit(CW_ER) | cw_bit(CW_LA);
          OP_ADD:  cw_raw = cw_bit(CW_ER) | cw_bit(CW_LB);
          OP_SUB:  cw_raw = cw_bit(CW_ER) | cw_bit(CW_LB) | cw_bit(CW_SU);
          default: cw_raw = CW_NONE;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD:  cw_raw = cw_bit(CW_EU) | cw_bit(CW_LA);
          OP_SUB:  cw_raw = cw_bit(CW_EU) | cw_bit(CW_LA) | cw_bit(CW_SU);
          default: cw_raw = CW_NONE;
        endcase
      end
      default: cw_raw = CW_NONE;
    endcase
  end

  // Qualify the raw word: reset and halt silence everything, a pause only
  // silences the load strobes so bus values stay visible while stepping.
  always_comb begin
    cw = cw_raw;
    if (!clr_n || halted) begin
      cw = CW_NONE;
    end else if (!adv) begin
      cw = cw_raw & ~CW_LOAD_MASK;
    end
  end

  assign cp = cw[CW_CP];
  assign ep = cw[CW_EP];
  assign lm = cw[CW_LM];
  assign er = cw[CW_ER];
  assign li = cw[CW_LI];
  assign ei = cw[CW_EI];
  assign la = cw[CW_LA];
  assign ea = cw[CW_EA];
  assign su = cw[CW_SU];
  assign eu = cw[CW_EU];
  assign lb = cw[CW_LB];
  assign lo = cw[CW_LO];

  a_single_bus_driver: assert property (@(posedge clk) disable iff (!clr_n)
    $onehot0(cw & CW_BUS_MASK));

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
module tb_sap1_controller_sequencer;

  logic       clk;
  logic       clr_n;
  logic [3:0] opcode;
  logic       run;
  logic       step;
  logic cp, ep, lm, er, li, ei, la, ea, su, eu, lb, lo;
  logic [5:0] t_state;
  logic       halted;

  int checks   = 0;
  int failures = 0;

  // Reference model state: T-state number 1..6, halt flag, last sampled step.
  int m_t;
  bit m_h;
  bit m_prev;

  string cname [12] = '{"cp", "ep", "lm", "er", "li", "ei", "la", "ea", "su", "eu", "lb", "lo"};

  sap1_controller_sequencer dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .opcode  (opcode),
    .run     (run),
    .step    (step),
    .cp      (cp),
    .ep      (ep),
    .lm      (lm),
    .er      (er),
    .li      (li),
    .ei      (ei),
    .la      (la),
    .ea      (ea),
    .su      (su),
    .eu      (eu),
    .lb      (lb),
    .lo      (lo),
    .t_state (t_state),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] vec_of(input string s);
    logic [11:0] v;
    string tok;
    v = '0;
    tok = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s.substr(i, i) == " ") begin
        for (int k = 0; k < 12; k++) if (tok == cname[k]) v[k] = 1'b1;
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return v;
  endfunction

  // SAP-1 microcode written as mnemonic lists per (T-state, opcode).
  function automatic string micro(input int t, input logic [3:0] op);
    case (t)
      1: return "ep lm";
      2: return "cp";
      3: return "er li";
      4: case (op)
           4'h0, 4'h1: return "ei lm";
           4'h2:       return "ei lm su";
           4'hE:       return "ea lo";
           default:    return "";
         endcase
      5: case (op)
           4'h0:    return "er la";
           4'h1:    return "er lb";
           4'h2:    return "er lb su";
           default: return "";
         endcase
      6: case (op)
           4'h1:    return "eu la";
           4'h2:    return "eu la su";
           default: return "";
         endcase
      default: return "";
    endcase
  endfunction

  function automatic logic [11:0] dut_ctl();
    return {lo, lb, eu, su, ea, la, ei, li, er, lm, ep, cp};
  endfunction

  function automatic bit exp_adv();
    return run | (step & ~m_prev);
  endfunction

  function automatic logic [11:0] exp_ctl();
    logic [11:0] v;
    if (!clr_n || m_h) return '0;
    v = vec_of(micro(m_t, opcode));
    if (!exp_adv()) v = v & ~vec_of("cp lm li la lb lo");
    return v;
  endfunction

  function automatic logic [5:0] exp_t();
    logic [5:0] one;
    one = 6'd1;
    return one << (m_t - 1);
  endfunction

  function automatic int bus_drivers();
    return $countones(dut_ctl() & vec_of("ep er ei ea eu"));
  endfunction

  task automatic model_reset();
    m_t = 1;
    m_h = 0;
    m_prev = 0;
  endtask

  // One clock edge; the model applies the advance rule to the inputs seen at the edge.
  task automatic tick();
    bit adv;
    @(posedge clk);
    if (!clr_n) begin
      model_reset();
    end else begin
      adv = exp_adv();
      m_prev = step;
      if (!m_h && adv) begin
        if (m_t == 4 && opcode == 4'hF) m_h = 1;
        else m_t = (m_t % 6) + 1;
      end
    end
    #1;
  endtask

  task automatic go_to_t1();
    run = 1'b1;
    step = 1'b0;
    opcode = 4'h0;
    for (int i = 0; i < 6 && m_t != 1; i++) tick();
  endtask

  task automatic test_reset();
    clr_n = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0;
    #2;
    clr_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (t_state !== 6'b000001) begin failures++; $display("FAIL reset_t_state got=%b want=%b", t_state, 6'b000001); end
    checks++;
    if (dut_ctl() !== 12'h000) begin failures++; $display("FAIL reset_ctl got=%h want=%h", dut_ctl(), 12'h000); end
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b want=0", halted); end
    tick();
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (t_state !== exp_t()) begin failures++; $display("FAIL post_reset_t_state got=%b want=%b", t_state, exp_t()); end
      tick();
    end
  endtask

  task automatic test_lda();
    go_to_t1();
    opcode = 4'h0;
    for (int c = 0; c < 7; c++) begin
      #1;
      checks++;
      if (dut_ctl() !== exp_ctl()) begin failures++; $display("FAIL lda_ctl cyc=%0d got=%h want=%h", c, dut_ctl(), exp_ctl()); end
      checks++;
      if (t_state !== exp_t()) begin failures++; $display("FAIL lda_t_state cyc=%0d got=%b want=%b", c, t_state, exp_t()); end
      tick();
    end
    checks++;
    if (t_state !== 6'b000010) begin failures++; $display("FAIL lda_latency got=%b want=%b", t_state, 6'b000010); end
  endtask

  task automatic test_add_sub();
    logic [3:0] ops [2];
    ops[0] = 4'h1;
    ops[1] = 4'h2;
    go_to_t1();
    foreach (ops[k]) begin
      opcode = ops[k];
      for (int c = 0; c < 6; c++) begin
        #1;
        checks++;
        if (dut_ctl() !== exp_ctl()) begin failures++; $display("FAIL addsub_ctl op=%h cyc=%0d got=%h want=%h", opcode, c, dut_ctl(), exp_ctl()); end
        checks++;
        if (bus_drivers() > 1) begin failures++; $display("FAIL addsub_bus op=%h cyc=%0d drivers=%0d want<=1", opcode, c, bus_drivers()); end
        if (c >= 3) begin
          checks++;
          if (su !== (opcode == 4'h2)) begin failures++; $display("FAIL addsub_su op=%h cyc=%0d got=%b want=%b", opcode, c, su, opcode == 4'h2); end
        end
        tick();
      end
    end
  endtask

  task automatic test_single_step();
    go_to_t1();
    run = 1'b0;
    step = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (dut_ctl() !== exp_ctl()) begin failures++; $display("FAIL step_ctl cyc=%0d got=%h want=%h", c, dut_ctl(), exp_ctl()); end
      if (c > 0) begin
        checks++;
        if ({cp, lm, li, la, lb, lo} !== 6'b0) begin failures++; $display("FAIL step_paused_loads cyc=%0d got=%b want=000000", c, {cp, lm, li, la, lb, lo}); end
      end
      tick();
    end
    checks++;
    if (t_state !== 6'b000010) begin failures++; $display("FAIL step_held got=%b want=%b", t_state, 6'b000010); end
    step = 1'b0;
    tick();
    tick();
    step = 1'b1;
    #1;
    checks++;
    if (dut_ctl() !== exp_ctl()) begin failures++; $display("FAIL step2_ctl got=%h want=%h", dut_ctl(), exp_ctl()); end
    tick();
    step = 1'b0;
    tick();
    checks++;
    if (t_state !== 6'b000100) begin failures++; $display("FAIL step_second got=%b want=%b", t_state, 6'b000100); end
  endtask

  task automatic test_out_illegal();
    logic [3:0] ops [2];
    ops[0] = 4'hE;
    ops[1] = 4'h7;
    go_to_t1();
    foreach (ops[k]) begin
      opcode = ops[k];
      for (int c = 0; c < 6; c++) begin
        #1;
        checks++;
        if (dut_ctl() !== exp_ctl()) begin failures++; $display("FAIL outnop_ctl op=%h cyc=%0d got=%h want=%h", opcode, c, dut_ctl(), exp_ctl()); end
        tick();
      end
      checks++;
      if (t_state !== 6'b000001) begin failures++; $display("FAIL outnop_wrap op=%h got=%b want=%b", opcode, t_state, 6'b000001); end
    end
  endtask

  task automatic test_hlt();
    go_to_t1();
    opcode = 4'hF;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (dut_ctl() !== exp_ctl()) begin failures++; $display("FAIL hlt_fetch_ctl cyc=%0d got=%h want=%h", c, dut_ctl(), exp_ctl()); end
      tick();
    end
    checks++;
    if (halted !== 1'b1) begin failures++; $display("FAIL hlt_flag got=%b want=1", halted); end
    for (int c = 0; c < 20; c++) begin
      step = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (t_state !== 6'b001000 || dut_ctl() !== 12'h000) begin
        failures++;
        $display("FAIL hlt_frozen cyc=%0d t_state=%b ctl=%h want t_state=001000 ctl=000", c, t_state, dut_ctl());
      end
      tick();
    end
    clr_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (t_state !== 6'b000001 || halted !== 1'b0) begin
      failures++;
      $display("FAIL hlt_clear t_state=%b halted=%b want t_state=000001 halted=0", t_state, halted);
    end
    tick();
    clr_n = 1'b1;
    step = 1'b0;
  endtask

  task automatic test_reset_mid();
    go_to_t1();
    opcode = 4'h1;
    for (int i = 0; i < 8 && m_t != 5; i++) tick();
    checks++;
    if (t_state !== 6'b010000) begin failures++; $display("FAIL midrst_reach_t5 got=%b want=%b", t_state, 6'b010000); end
    #2;
    clr_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (t_state !== 6'b000001 || dut_ctl() !== 12'h000 || halted !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async t_state=%b ctl=%h halted=%b want 000001/000/0", t_state, dut_ctl(), halted);
    end
    tick();
    clr_n = 1'b1;
  endtask

  task automatic test_random();
    int halt_cycles;
    halt_cycles = 0;
    go_to_t1();
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) run = ($urandom_range(0, 2) == 0);
      step = 1'($urandom_range(0, 1));
      if (m_t == 1 && !m_h) opcode = 4'($urandom_range(0, 15));
      if (m_h) halt_cycles++;
      if (halt_cycles > 3 || $urandom_range(0, 99) == 0) begin
        clr_n = 1'b0;
        model_reset();
        halt_cycles = 0;
      end else begin
        clr_n = 1'b1;
      end
      #1;
      checks++;
      if (dut_ctl() !== exp_ctl()) begin failures++; $display("FAIL rand_ctl cyc=%0d op=%h t=%0d got=%h want=%h", c, opcode, m_t, dut_ctl(), exp_ctl()); end
      checks++;
      if (t_state !== exp_t() || halted !== m_h) begin
        failures++;
        $display("FAIL rand_state cyc=%0d t_state=%b halted=%b want t_state=%b halted=%b", c, t_state, halted, exp_t(), m_h);
      end
      checks++;
      if (bus_drivers() > 1) begin failures++; $display("FAIL rand_bus cyc=%0d drivers=%0d want<=1", c, bus_drivers()); end
      tick();
    end
    clr_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lda();
    test_add_sub();
    test_single_step();
    test_out_illegal();
    test_hlt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
